prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the program ROM interface: fills instruction memory that the CPU core fetches from.
- Receives a byte stream over a valid/ready handshake from a UART/host link.
- Assembles 18-bit instruction words and writes them sequentially into program memory.
- Holds the CPU in hold until a successful load completes.

Parameters:
- BASE_ADDR, 16'h0000, first program-memory address written.
- DEPTH, 1024, maximum words accepted; larger counts are an error.
- HOLD_AT_RESET, 1, reset value of o_cpu_hold.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  one-cycle pulse that begins a load; ignored while o_busy.
- i_rx_data  in  8  incoming byte.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  loader can accept a byte this cycle.
- o_mem_addr  out  16  program-memory write address.
- o_mem_data  out  18  instruction word to write.
- o_mem_we  out  1  one-cycle write strobe.
- o_busy  out  1  load in progress.
- o_cpu_hold  out  1  keeps the CPU stalled/in reset.
- o_done  out  1  level, last load succeeded.
- o_error  out  1  level, last load failed.
- o_word_count  out  16  words written so far in the current load.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, except o_cpu_hold = HOLD_AT_RESET.
- Byte transfer: a byte is consumed only on a cycle with i_rx_valid && o_rx_ready.
- o_rx_ready is 1 only in LEN_HI, LEN_LO, B0, B1, B2, CSUM.
- States:
  - IDLE: on i_start, clear o_done, o_error, o_word_count and the sum; set o_busy and o_cpu_hold; go to LEN_HI.
  - LEN_HI, LEN_LO: capture the 16-bit big-endian word count N.
    - After LEN_LO: N > DEPTH goes to ERROR.
    - N == 0 goes to CSUM (macro on) or DONE (macro off).
    - Otherwise go to B0.
  - B0: byte bits[1:0] become instruction bits 17:16. Any of bits[7:2] nonzero goes to ERROR.
  - B1: bits 15:8. B2: bits 7:0. Then go to WRITE.
  - WRITE: exactly one cycle.
    - o_mem_we = 1, o_mem_addr = BASE_ADDR + o_word_count, o_mem_data = assembled word.
    - o_word_count increments the next cycle.
    - Go to B0 if words remain, otherwise CSUM/DONE.
  - DONE: o_busy = 0, o_done = 1, o_cpu_hold = 0. Stay until i_start.
  - ERROR: o_busy = 0, o_error = 1, o_cpu_hold remains 1. Stay until i_start.
- Latency: memory write occurs the cycle after the third word byte is accepted. Fastest rate is one word per 4 cycles.
- o_mem_addr and o_mem_data are held stable outside WRITE. o_mem_we is never high outside WRITE.
- Address arithmetic is 16-bit modulo. BASE_ADDR + DEPTH must not exceed 2^16 (parameter check at elaboration).
- i_start in DONE/ERROR begins a new load. i_start in any busy state is ignored.
- Reset mid-load aborts immediately. Partially written memory is not cleaned up.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) covers every byte accepted after i_start: both length bytes and all payload bytes.
  - After the last WRITE (or after LEN_LO when N = 0), state CSUM accepts one byte.
  - Byte equal to the sum goes to DONE; otherwise go to ERROR.
- Disabled:
  - No CSUM state and no sum register.
  - Last WRITE goes directly to DONE; no trailing byte is consumed.

Decomposition:
- Package prog_loader_pkg holds:
  - State enum.
  - Constants INSTR_W = 18, ADDR_W = 16, BYTES_PER_WORD = 3.
- One natural sub-module: word_assembler, the byte-to-18-bit shift/capture with the B0 format check. The FSM, counters and checksum stay in prog_loader.

Test Plan:
- Single word, macro on:
  - Stimulus: i_start; bytes 00 01 02 AB CD 7B.
  - Response: one o_mem_we with addr 0000 and data 18'h2ABCD. Then o_done = 1, o_cpu_hold = 0, o_word_count = 1.
- Bad checksum: same stream ending 7C -> write still occurs; ends in ERROR with o_error = 1 and o_cpu_hold = 1.
- Format error: N = 1, first word byte 0x04 -> ERROR immediately; no o_mem_we; later bytes not accepted (o_rx_ready = 0).
- Oversize and zero length:
  - N = 0x0401 with DEPTH = 1024 -> ERROR after LEN_LO.
  - N = 0 with checksum byte 00 -> DONE, zero writes.
- Backpressure and throughput: 3 words with i_rx_valid toggling randomly -> addresses 0,1,2 written in order with correct data. o_rx_ready is low on every WRITE cycle.
- Async reset: assert i_reset_n = 0 mid-B1 -> outputs return to reset values without a clock edge. A subsequent full load then succeeds.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program-ROM loader.
// Holds the loader state enum and the instruction/address geometry.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds the trailing-checksum state.
package prog_loader_pkg;

  localparam int INSTR_W        = 18;
  localparam int ADDR_W         = 16;
  localparam int BYTES_PER_WORD = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// prog_loader_word_assembler: packs three received bytes into one instruction word.
// Ports: i_clock/i_reset_n; i_byte with per-position capture strobes i_cap_b0..b2;
//        o_word (full word, updated on the third byte); o_fmt_err (high-byte format check).
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [7:0]         i_byte,
  input  logic               i_cap_b0,
  input  logic               i_cap_b1,
  input  logic               i_cap_b2,
  output logic [INSTR_W-1:0] o_word,
  output logic               o_fmt_err
);

  if (INSTR_W > BYTES_PER_WORD * 8) begin : g_bad_geometry
    $error("prog_loader_word_assembler: instruction does not fit in the byte count");
  end

  logic [1:0]         hi_q;
  logic [7:0]         mid_q;
  logic [INSTR_W-1:0] word_q;

  // Only the two low bits of the first byte carry instruction bits.
  assign o_fmt_err = |i_byte[7:2];

  // word_q changes only when the last byte lands, so it stays stable
  // while the next word's first two bytes are being collected.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hi_q   <= '0;
      mid_q  <= '0;
      word_q <= '0;
    end else begin
      if (i_cap_b0) hi_q   <= i_byte[1:0];
      if (i_cap_b1) mid_q  <= i_byte;
      if (i_cap_b2) word_q <= {hi_q, mid_q, i_byte};
    end
  end

  assign o_word = word_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream and writes 18-bit words to program memory.
// Ports: i_clock/i_reset_n, i_start pulse, i_rx_* valid/ready byte input, o_mem_* write port,
//        o_busy/o_done/o_error/o_cpu_hold status, o_word_count. Macro: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int unsigned DEPTH         = 1024,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [INSTR_W-1:0] o_mem_data,
  output logic               o_mem_we,
  output logic               o_busy,
  output logic               o_cpu_hold,
  output logic               o_done,
  output logic               o_error,
  output logic [15:0]        o_word_count
);

  if ((32'(BASE_ADDR) + 32'(DEPTH)) > 32'h0001_0000) begin : g_bad_range
    $error("prog_loader: BASE_ADDR + DEPTH exceeds the 16-bit address space");
  end

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hold_q, hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic                accept;
  logic                cap_b0, cap_b1, cap_b2;
  logic                fmt_err;
  logic [INSTR_W-1:0]  word;
  logic                finish_ok, go_done, go_error;
  logic [16:0]         len_full;

  always_comb begin
    o_rx_ready = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_B0, ST_B1, ST_B2: o_rx_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM:                                   o_rx_ready = 1'b1;
`endif
      default:                                   o_rx_ready = 1'b0;
    endcase
  end

  assign accept   = i_rx_valid && o_rx_ready;
  assign cap_b0   = accept && (state_q == ST_B0) && !fmt_err;
  assign cap_b1   = accept && (state_q == ST_B1);
  assign cap_b2   = accept && (state_q == ST_B2);
  assign len_full = {1'b0, len_q[15:8], i_rx_data};

  prog_loader_word_assembler u_asm (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_byte    (i_rx_data),
    .i_cap_b0  (cap_b0),
    .i_cap_b1  (cap_b1),
    .i_cap_b2  (cap_b2),
    .o_word    (word),
    .o_fmt_err (fmt_err)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    hold_d    = hold_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    finish_ok = 1'b0;
    go_done   = 1'b0;
    go_error  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {i_rx_data, len_q[7:0]};
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d = len_full[15:0];
          if (len_full > DEPTH_L)  go_error  = 1'b1;
          else if (len_full == '0) finish_ok = 1'b1;
          else                     state_d   = ST_B0;
        end
      end
      ST_B0: begin
        if (accept) begin
          if (fmt_err) go_error = 1'b1;
          else         state_d  = ST_B1;
        end
      end
      ST_B1: begin
        if (accept) state_d = ST_B2;
      end
      ST_B2: begin
        if (accept) begin
          // Address is latched here so it is stable for the whole WRITE cycle.
          addr_d  = BASE_ADDR + cnt_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 16'd1;
        if ((cnt_q + 16'd1) == len_q) finish_ok = 1'b1;
        else                          state_d   = ST_B0;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (i_rx_data == sum_q) go_done  = 1'b1;
          else                    go_error = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (finish_ok) begin
`ifdef PROG_LOADER_CHECKSUM_EN
      state_d = ST_CSUM;
`else
      go_done = 1'b1;
`endif
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // The checksum byte itself is not part of the sum.
    if (accept && (state_q != ST_CSUM)) sum_d = sum_q + i_rx_data;
`endif

    if (go_done) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      hold_d  = 1'b0;
    end
    if (go_error) begin
      state_d = ST_ERROR;
      busy_d  = 1'b0;
      error_d = 1'b1;
      hold_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign o_mem_we     = (state_q == ST_WRITE);
  assign o_mem_addr   = addr_q;
  assign o_mem_data   = word;
  assign o_busy       = busy_q;
  assign o_cpu_hold   = hold_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a write scoreboard.
// Expected memory writes are queued as words are sent and popped by a write monitor.
// Adapts to the PROG_LOADER_CHECKSUM_EN build by sending/omitting the trailing byte.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        o_rx_ready;
  logic [15:0] o_mem_addr;
  logic [17:0] o_mem_data;
  logic        o_mem_we;
  logic        o_busy;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_word_count;

  typedef struct packed {
    logic [15:0] a;
    logic [17:0] d;
  } wr_t;

  wr_t  sb_q[$];
  wr_t  mon_e;
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt = 0;
  int   wr_base;
  logic [7:0]  csum;
  logic [17:0] w;

  always #5 clk = ~clk;

  prog_loader dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_we     (o_mem_we),
    .o_busy       (o_busy),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_mem_we === 1'b1) begin
      wr_cnt++;
      check("wr_rx_ready_low", 32'(o_rx_ready), 32'd0);
      check("wr_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(o_mem_addr), 32'(mon_e.a));
        check("wr_data", 32'(o_mem_data), 32'(mon_e.d));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    csum  = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (o_rx_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = 1'b1;
      end
    end
    rx_valid = 1'b0;
    csum = csum + b;
    check("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_word(input logic [17:0] wd, input logic [15:0] addr, input int gap);
    wr_t e;
    e.a = addr;
    e.d = wd;
    sb_q.push_back(e);
    send_byte({6'b0, wd[17:16]}, gap);
    send_byte(wd[15:8], gap);
    send_byte(wd[7:0], gap);
  endtask

  task automatic wait_end();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_error === 1'b1) seen = 1'b1;
    end
    check("end_reached", 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; csum = 8'h00;
    #12;
    check("rst_busy",  32'(o_busy), 32'd0);
    check("rst_done",  32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_hold",  32'(o_cpu_hold), 32'd1);
    check("rst_we",    32'(o_mem_we), 32'd0);
    check("rst_ready", 32'(o_rx_ready), 32'd0);
    check("rst_count", 32'(o_word_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word 0x2ABCD, good checksum 0x7B.
    wr_base = wr_cnt;
    pulse_start();
    check("start_busy", 32'(o_busy), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(18'h2ABCD, 16'h0000, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("csum_model", 32'(csum), 32'h7B);
    send_byte(csum, 0);
`endif
    wait_end();
    check("one_done",  32'(o_done), 32'd1);
    check("one_error", 32'(o_error), 32'd0);
    check("one_hold",  32'(o_cpu_hold), 32'd0);
    check("one_busy",  32'(o_busy), 32'd0);
    check("one_count", 32'(o_word_count), 32'd1);
    check("one_writes", 32'(wr_cnt - wr_base), 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum: write still happens, load ends in error.
    @(posedge clk); #1;
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(18'h2ABCD, 16'h0000, 0);
    send_byte(csum + 8'h01, 0);
    wait_end();
    check("badsum_error", 32'(o_error), 32'd1);
    check("badsum_done",  32'(o_done), 32'd0);
    check("badsum_hold",  32'(o_cpu_hold), 32'd1);
    check("badsum_writes", 32'(wr_cnt - wr_base), 32'd1);
`endif

    // Format error on the first word byte.
    @(posedge clk); #1;
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    wait_end();
    check("fmt_error", 32'(o_error), 32'd1);
    check("fmt_hold",  32'(o_cpu_hold), 32'd1);
    rx_data = 8'h55; rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fmt_no_ready", 32'(o_rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    check("fmt_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Oversize length 0x0401.
    @(posedge clk); #1;
    pulse_start();
    check("restart_clears_error", 32'(o_error), 32'd0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    wait_end();
    check("big_error", 32'(o_error), 32'd1);
    check("big_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Zero length.
    @(posedge clk); #1;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum, 0);
`endif
    wait_end();
    check("zero_done",  32'(o_done), 32'd1);
    check("zero_error", 32'(o_error), 32'd0);
    check("zero_count", 32'(o_word_count), 32'd0);
    check("zero_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Three words with random gaps; a stray start mid-load must be ignored.
    @(posedge clk); #1;
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'h00, $urandom_range(0, 2));
    send_byte(8'h03, $urandom_range(0, 2));
    pulse_start_ignored: begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      w = 18'($urandom);
      send_word(w, 16'(k), $urandom_range(0, 2));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum, $urandom_range(0, 2));
`endif
    wait_end();
    check("bp_done",   32'(o_done), 32'd1);
    check("bp_count",  32'(o_word_count), 32'd3);
    check("bp_writes", 32'(wr_cnt - wr_base), 32'd3);
    check("bp_addr_held", 32'(o_mem_addr), 32'd2);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Async reset in B1 of the second word.
    @(posedge clk); #1;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(18'h1F00F, 16'h0000, 0);
    send_byte(8'h01, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(o_busy), 32'd0);
    check("arst_hold",  32'(o_cpu_hold), 32'd1);
    check("arst_ready", 32'(o_rx_ready), 32'd0);
    check("arst_count", 32'(o_word_count), 32'd0);
    check("arst_data",  32'(o_mem_data), 32'd0);
    check("arst_done",  32'(o_done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wr_base = wr_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(18'h31234, 16'h0000, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(csum, 0);
`endif
    wait_end();
    check("post_done",   32'(o_done), 32'd1);
    check("post_hold",   32'(o_cpu_hold), 32'd0);
    check("post_writes", 32'(wr_cnt - wr_base), 32'd1);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
